// File: rtl/id_stage_if.sv
// IF/ID -> ID -> ID/EX boundary of the MIPS pipeline: fetched instruction, write-back
// port, stall feedback and the registered decode results handed to EX.
interface id_stage_if #(
   parameter int DATA_W = 32
);
   // fetch side and write-back
   logic [31:0]       next_ins_adr_in;
   logic [31:0]       cur_ins_in;
   logic              flush;
   logic              wb_reg_write;
   logic [4:0]        wb_write_reg;
   logic [DATA_W-1:0] wb_write_data;
   logic              stall;

   // ID/EX pipeline register
   logic [31:0]       next_ins_adr_out;
   logic [DATA_W-1:0] read_data_1_out;
   logic [DATA_W-1:0] read_data_2_out;
   logic [31:0]       sign_ext_out;
   logic [4:0]        rs_out;
   logic [4:0]        rt_out;
   logic [4:0]        rd_out;
   logic              reg_dst;
   logic              alu_src;
   logic              mem_to_reg;
   logic              reg_write;
   logic              mem_read;
   logic              mem_write;
   logic              branch;
   logic [1:0]        alu_op;

   modport slave (
      input  next_ins_adr_in, cur_ins_in, flush,
      input  wb_reg_write, wb_write_reg, wb_write_data,
      output stall,
      output next_ins_adr_out, read_data_1_out, read_data_2_out, sign_ext_out,
      output rs_out, rt_out, rd_out,
      output reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op
   );

   modport master (
      output next_ins_adr_in, cur_ins_in, flush,
      output wb_reg_write, wb_write_reg, wb_write_data,
      input  stall,
      input  next_ins_adr_out, read_data_1_out, read_data_2_out, sign_ext_out,
      input  rs_out, rt_out, rd_out,
      input  reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op
   );
endinterface

// File: rtl/id_stage.sv
// Instruction-decode stage: control decode, 32x32 register file with write-through
// bypass, sign extension, load-use stall detection and the ID/EX pipeline register.
module id_stage #(
   parameter int DATA_W    = 32,
   parameter bit HAZARD_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   id_stage_if.slave  bus
);

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic [1:0] alu_op;
   } ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   logic [31:0]       ins;
   logic [5:0]        opcode;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        rd;
   ctrl_t             dec_ctrl;
   ctrl_t             ctrl_q;
   logic [DATA_W-1:0] regs [32];
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic [31:0]       adr_q;
   logic [DATA_W-1:0] rd1_q;
   logic [DATA_W-1:0] rd2_q;
   logic [31:0]       sext_q;
   logic [4:0]        rs_q;
   logic [4:0]        rt_q;
   logic [4:0]        rd_q;
   logic              load_use;
   logic              bubble;

   assign ins    = bus.cur_ins_in;
   assign opcode = ins[31:26];
   assign rs     = ins[25:21];
   assign rt     = ins[20:16];
   assign rd     = ins[15:11];

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      dec_ctrl = '0;
      unique case (opcode)
         OP_RTYPE: begin
            dec_ctrl.reg_dst   = 1'b1;
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.alu_op    = 2'b10;
         end
         OP_LW: begin
            dec_ctrl.alu_src    = 1'b1;
            dec_ctrl.mem_to_reg = 1'b1;
            dec_ctrl.reg_write  = 1'b1;
            dec_ctrl.mem_read   = 1'b1;
         end
         OP_SW: begin
            dec_ctrl.alu_src   = 1'b1;
            dec_ctrl.mem_write = 1'b1;
         end
         OP_BEQ: begin
            dec_ctrl.branch = 1'b1;
            dec_ctrl.alu_op = 2'b01;
         end
         OP_ADDI: begin
            dec_ctrl.alu_src   = 1'b1;
            dec_ctrl.reg_write = 1'b1;
         end
         default: dec_ctrl = '0;
      endcase
   end

   // NOTE: the register file is cleared by the async reset, so it is built from flops rather than a RAM macro.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (bus.wb_reg_write && (bus.wb_write_reg != 5'd0)) begin
         regs[bus.wb_write_reg] <= bus.wb_write_data;
      end
   end

   // Write-through: a read of the register being written this cycle sees the new value.
   function automatic logic [DATA_W-1:0] read_reg(input logic [4:0] a);
      if (a == 5'd0)                                  return '0;
      else if (bus.wb_reg_write && bus.wb_write_reg == a) return bus.wb_write_data;
      else                                            return regs[a];
   endfunction

   always_comb begin
      rd1 = read_reg(rs);
      rd2 = read_reg(rt);
   end

   assign load_use  = ctrl_q.mem_read && (rt_q != 5'd0) && ((rt_q == rs) || (rt_q == rt));
   assign bus.stall = HAZARD_EN && load_use;
   assign bubble    = bus.stall || bus.flush;

   // NOTE: pipeline state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q <= '0;
         adr_q  <= '0;
         rd1_q  <= '0;
         rd2_q  <= '0;
         sext_q <= '0;
         rs_q   <= '0;
         rt_q   <= '0;
         rd_q   <= '0;
      end else begin
         ctrl_q <= bubble ? ctrl_t'('0) : dec_ctrl;
         adr_q  <= bus.next_ins_adr_in;
         rd1_q  <= rd1;
         rd2_q  <= rd2;
         sext_q <= {{16{ins[15]}}, ins[15:0]};
         rs_q   <= rs;
         rt_q   <= rt;
         rd_q   <= rd;
      end
   end

   assign bus.next_ins_adr_out = adr_q;
   assign bus.read_data_1_out  = rd1_q;
   assign bus.read_data_2_out  = rd2_q;
   assign bus.sign_ext_out     = sext_q;
   assign bus.rs_out           = rs_q;
   assign bus.rt_out           = rt_q;
   assign bus.rd_out           = rd_q;
   assign bus.reg_dst          = ctrl_q.reg_dst;
   assign bus.alu_src          = ctrl_q.alu_src;
   assign bus.mem_to_reg       = ctrl_q.mem_to_reg;
   assign bus.reg_write        = ctrl_q.reg_write;
   assign bus.mem_read         = ctrl_q.mem_read;
   assign bus.mem_write        = ctrl_q.mem_write;
   assign bus.branch           = ctrl_q.branch;
   assign bus.alu_op           = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed cases from the decode/hazard rules followed
// by randomized instruction streams compared against a behavioural pipeline model.
module tb_id_stage;

   localparam bit HAZARD_EN = 1'b1;

   logic clk = 1'b0;
   logic rst_n;

   id_stage_if #(.DATA_W(32)) bus ();

   id_stage #(.DATA_W(32), .HAZARD_EN(HAZARD_EN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference state: architectural registers and the expected ID/EX contents
   logic [31:0] mregs [32];
   logic [31:0] e_adr, e_rd1, e_rd2, e_sext;
   logic [4:0]  e_rs, e_rt, e_rd;
   logic [8:0]  e_ctrl;  // {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op}
   logic        last_stall;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [8:0] ref_ctrl(input logic [5:0] op);
      case (op)
         6'h00:   return 9'b1_0_0_1_0_0_0_10;
         6'h23:   return 9'b0_1_1_1_1_0_0_00;
         6'h2B:   return 9'b0_1_0_0_0_1_0_00;
         6'h04:   return 9'b0_0_0_0_0_0_1_01;
         6'h08:   return 9'b0_1_0_1_0_0_0_00;
         default: return 9'b0;
      endcase
   endfunction

   function automatic logic [31:0] ref_read(input logic [4:0] a, input logic wen,
                                            input logic [4:0] wr, input logic [31:0] wd);
      if (a == 5'd0)            return 32'd0;
      if (wen && wr == a)       return wd;
      return mregs[a];
   endfunction

   function automatic logic [8:0] obs_ctrl();
      return {bus.reg_dst, bus.alu_src, bus.mem_to_reg, bus.reg_write, bus.mem_read,
              bus.mem_write, bus.branch, bus.alu_op};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      e_adr = 0; e_rd1 = 0; e_rd2 = 0; e_sext = 0;
      e_rs = 0; e_rt = 0; e_rd = 0; e_ctrl = 0;
      last_stall = 1'b0;
   endtask

   task automatic check_outputs();
      check("next_ins_adr", bus.next_ins_adr_out, e_adr);
      check("read_data_1",  bus.read_data_1_out,  e_rd1);
      check("read_data_2",  bus.read_data_2_out,  e_rd2);
      check("sign_ext",     bus.sign_ext_out,     e_sext);
      check("rs_rt_rd",     {17'd0, bus.rs_out, bus.rt_out, bus.rd_out}, {17'd0, e_rs, e_rt, e_rd});
      check("ctrl",         {23'd0, obs_ctrl()}, {23'd0, e_ctrl});
   endtask

   // One cycle: drive at negedge, check STALL combinationally, clock, check ID/EX at next negedge.
   task automatic step(input logic [31:0] ins, input logic fl, input logic wen,
                       input logic [4:0] wr, input logic [31:0] wd);
      logic [31:0] adr;
      logic        ex_stall;
      logic [4:0]  rs, rt;
      adr = $urandom;
      rs  = ins[25:21];
      rt  = ins[20:16];
      bus.next_ins_adr_in = adr;
      bus.cur_ins_in      = ins;
      bus.flush           = fl;
      bus.wb_reg_write    = wen;
      bus.wb_write_reg    = wr;
      bus.wb_write_data   = wd;
      ex_stall = HAZARD_EN && e_ctrl[4] && (e_rt != 5'd0) && (e_rt == rs || e_rt == rt);
      #1;
      check("stall", {31'd0, bus.stall}, {31'd0, ex_stall});
      last_stall = ex_stall;
      e_adr  = adr;
      e_rd1  = ref_read(rs, wen, wr, wd);
      e_rd2  = ref_read(rt, wen, wr, wd);
      e_sext = {{16{ins[15]}}, ins[15:0]};
      e_rs   = rs;
      e_rt   = rt;
      e_rd   = ins[15:11];
      e_ctrl = (ex_stall || fl) ? 9'd0 : ref_ctrl(ins[31:26]);
      @(posedge clk);
      if (wen && wr != 5'd0) mregs[wr] = wd;
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] ins;
      logic [5:0]  ops [6];
      ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B;
      ops[3] = 6'h04; ops[4] = 6'h08; ops[5] = 6'h3F;

      rst_n = 1'b0;
      bus.next_ins_adr_in = 0; bus.cur_ins_in = 0; bus.flush = 0;
      bus.wb_reg_write = 0; bus.wb_write_reg = 0; bus.wb_write_data = 0;
      model_reset();
      #3;
      check("reset_stall", {31'd0, bus.stall}, 32'd0);
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      // write then read $5
      step(32'hFC00_0000, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
      step(32'h00A5_3020, 1'b0, 1'b0, 5'd0, 32'd0);
      check("wr_rd1", bus.read_data_1_out, 32'hDEAD_BEEF);
      check("wr_rd2", bus.read_data_2_out, 32'hDEAD_BEEF);
      check("wr_ctrl", {23'd0, obs_ctrl()}, 32'b1_0_0_1_0_0_0_10);
      // same-cycle write-through on $9
      step(32'h0129_3020, 1'b0, 1'b1, 5'd9, 32'hDEAD_BEEF);
      check("bypass_rd1", bus.read_data_1_out, 32'hDEAD_BEEF);
      // $0 is never written and never bypassed
      step(32'h0000_0020, 1'b0, 1'b1, 5'd0, 32'h0000_1234);
      check("zero_bypass", bus.read_data_1_out, 32'd0);
      step(32'h0000_0020, 1'b0, 1'b0, 5'd0, 32'd0);
      check("zero_later", bus.read_data_2_out, 32'd0);

      // load-use: lw $2 then add $3,$2,$4
      step(32'h8C22_0000, 1'b0, 1'b0, 5'd0, 32'd0);
      step(32'h0044_1820, 1'b0, 1'b0, 5'd0, 32'd0);
      check("lu_stall", {31'd0, last_stall}, 32'd1);
      check("lu_bubble", {23'd0, obs_ctrl()}, 32'd0);
      step(32'h0044_1820, 1'b0, 1'b0, 5'd0, 32'd0);
      check("lu_release", {31'd0, last_stall}, 32'd0);
      check("lu_add", {23'd0, obs_ctrl()}, 32'b1_0_0_1_0_0_0_10);

      // flush squashes sw
      step(32'hAC22_0004, 1'b1, 1'b0, 5'd0, 32'd0);
      check("flush_mw", {31'd0, bus.mem_write}, 32'd0);
      check("flush_sext", bus.sign_ext_out, 32'h0000_0004);

      // beq with negative offset, then unknown opcode
      step(32'h1022_FFFF, 1'b0, 1'b0, 5'd0, 32'd0);
      check("beq_sext", bus.sign_ext_out, 32'hFFFF_FFFF);
      check("beq_ctrl", {23'd0, obs_ctrl()}, 32'b0_0_0_0_0_0_1_01);
      step(32'hFC00_0000, 1'b0, 1'b0, 5'd0, 32'd0);
      check("unk_ctrl", {23'd0, obs_ctrl()}, 32'd0);

      // mid-stream async reset with a lw in flight
      step(32'h8C22_0010, 1'b0, 1'b1, 5'd7, 32'h1111_2222);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("mid_reset_stall", {31'd0, bus.stall}, 32'd0);
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      step(32'h00E5_3020, 1'b0, 1'b0, 5'd0, 32'd0);
      check("reset_cleared_rf", bus.read_data_1_out, 32'd0);

      // randomized stream; small register indices make load-use collisions frequent
      ins = 32'd0;
      for (int n = 0; n < 400; n++) begin
         if (!last_stall) begin
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 5)];
            ins[25:21] = 5'($urandom_range(0, 4));
            ins[20:16] = 5'($urandom_range(0, 4));
         end
         step(ins, ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1),
              5'($urandom_range(0, 6)), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline; consumer end of the IF/ID register interface (NEXT_INS_ADR / CUR_INS).
- Decodes the instruction, reads a 32x32 register file (written back from WB), sign-extends the immediate and detects load-use hazards.
- Drives STALL back to the fetch side and registers all results into the ID/EX pipeline register.

Parameters:
- DATA_W, 32, datapath/register width
- HAZARD_EN, 1, 1 = load-use stall detection enabled; 0 = STALL tied 0

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- NEXT_INS_ADR_IN  in  32  PC+4 from IF/ID register
- CUR_INS_IN  in  32  instruction from IF/ID register
- FLUSH  in  1  branch taken in MEM; squash instruction entering ID/EX
- WB_REG_WRITE  in  1  write-back enable
- WB_WRITE_REG  in  5  write-back destination
- WB_WRITE_DATA  in  DATA_W  write-back data
- STALL  out  1  combinational; fetch side holds PC and IF/ID while high
- NEXT_INS_ADR_OUT  out  32  registered PC+4
- READ_DATA_1_OUT, READ_DATA_2_OUT  out  DATA_W  registered rs/rt values
- SIGN_EXT_OUT  out  32  registered sign-extended imm[15:0]
- RS_OUT, RT_OUT, RD_OUT  out  5 each  registered ins[25:21], [20:16], [15:11]
- REG_DST, ALU_SRC, MEM_TO_REG, REG_WRITE, MEM_READ, MEM_WRITE, BRANCH  out  1 each  registered control
- ALU_OP  out  2  registered ALU class

Behaviour:
- Reset (RST_N=0, async): every output register and all 32 regfile entries = 0; STALL = 0. Reset mid-stream discards in-flight ID/EX contents immediately.
- Latency: ID/EX outputs reflect CUR_INS_IN sampled at the rising edge; exactly 1 cycle.
- Decode by opcode ins[31:26]:
  - 0x00 R-type: REG_DST=1, REG_WRITE=1, ALU_OP=10.
  - 0x23 lw: ALU_SRC=1, MEM_TO_REG=1, REG_WRITE=1, MEM_READ=1, ALU_OP=00.
  - 0x2B sw: ALU_SRC=1, MEM_WRITE=1, ALU_OP=00.
  - 0x04 beq: BRANCH=1, ALU_OP=01.
  - 0x08 addi: ALU_SRC=1, REG_WRITE=1, ALU_OP=00.
  - Any other opcode: all control 0 (NOP); data fields still registered.
- Register file:
  - Write at rising edge when WB_REG_WRITE=1 and WB_WRITE_REG!=0.
  - $0 always reads 0.
  - Same-cycle read of the register being written returns WB_WRITE_DATA (write-through bypass), except $0.
- Sign extension: SIGN_EXT_OUT = {16{ins[15]}, ins[15:0]}.
- Load-use hazard (HAZARD_EN=1): STALL=1 when MEM_READ (current output) =1, RT_OUT!=0, and RT_OUT equals ins[25:21] or ins[20:16].
- Bubble: on STALL or FLUSH, the next edge loads all nine control outputs with 0; data/index outputs load normally. The stalled instruction is re-presented by IF/ID and re-decoded next cycle.
- STALL and FLUSH together: bubble; STALL still asserted (fetch side gives flush priority).
- STALL never holds more than 1 consecutive cycle, since the bubble clears MEM_READ.

Test Plan:
- Reset: RST_N low mid-cycle -> all outputs 0 and STALL 0 immediately, without waiting for a clock edge.
- Write then read: WB write $5=0xDEADBEEF, then ins 0x00A53020 (add $6,$5,$5) -> both READ_DATA outputs 0xDEADBEEF; REG_DST=1, REG_WRITE=1, ALU_OP=10. Repeat with write and read in the same cycle -> bypassed value 0xDEADBEEF.
- $0 protection: WB write $0=0x1234 -> a later read of $0 returns 0.
- Load-use: ins 0x8C220000 (lw $2,0($1)), next 0x00441820 (add $3,$2,$4):
  - STALL=1 for exactly 1 cycle.
  - Control outputs all 0 for 1 cycle.
  - Add decoded on the following edge, STALL=0.
- Flush: FLUSH=1 with ins 0xAC220004 (sw) -> MEM_WRITE=0 next cycle; SIGN_EXT_OUT=0x00000004.
- Sign extension and branch: ins 0x1022FFFF (beq) -> SIGN_EXT_OUT=0xFFFFFFFF, BRANCH=1, ALU_OP=01. Unknown opcode 0x3F -> all control 0.
